// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths and requester ids for the writeback arbiter
package regfile_wb_arbiter_pkg;
  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;
  localparam int AW_D = 5;
  typedef enum logic {REQ_ALU = 1'b0, REQ_LSU = 1'b1} req_id_e;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requesters, register file write port and issue scoreboard signals
interface regfile_wb_arbiter_if #(parameter int XLEN = 32, parameter int NREG = 32, parameter int AW = 5);
  logic alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0] alu_rd, lsu_rd;
  logic [XLEN-1:0] alu_data, lsu_data;
  logic rf_we;
  logic [AW-1:0] rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic iss_valid, iss_hazard;
  logic [AW-1:0] iss_rd, iss_rs1, iss_rs2;
  logic [NREG-1:0] pending;
  modport slave (
    input alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, iss_valid, iss_rd, iss_rs1, iss_rs2,
    output alu_ready, lsu_ready, rf_we, rf_wa, rf_wd, iss_hazard, pending
  );
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, iss_valid, iss_rd, iss_rs1, iss_rs2,
    input alu_ready, lsu_ready, rf_we, rf_wa, rf_wd, iss_hazard, pending
  );
endinterface

// File: rtl/regfile_wb_arbiter_wb_rr_arbiter.sv
// wb_rr_arbiter: two-way round-robin grant; last-grant moves only on a transfer
module wb_rr_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic alu_ready,
  output logic lsu_ready
);
  req_id_e last;
  always_comb begin
    alu_ready = !rst && alu_valid && (!lsu_valid || last == REQ_LSU);
    lsu_ready = !rst && lsu_valid && (!alu_valid || last == REQ_ALU);
  end
  always_ff @(posedge clk)
    if (rst) last <= REQ_LSU;
    else if (alu_ready) last <= REQ_ALU;
    else if (lsu_ready) last <= REQ_LSU;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU/LSU writebacks onto one register file write port.
// Define WB_SCOREBOARD_EN to build the per-register pending scoreboard and issue hazard check.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  parameter int AW = AW_D
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);
  logic alu_ready, lsu_ready, take, wr, we;
  logic [AW-1:0] sel_rd, wa;
  logic [XLEN-1:0] sel_data, wd;
  wb_rr_arbiter u_arb (
    .clk(clk),
    .rst(rst),
    .alu_valid(bus.alu_valid),
    .lsu_valid(bus.lsu_valid),
    .alu_ready(alu_ready),
    .lsu_ready(lsu_ready)
  );
  always_comb begin
    take = alu_ready || lsu_ready;
    sel_rd = alu_ready ? bus.alu_rd : bus.lsu_rd;
    sel_data = alu_ready ? bus.alu_data : bus.lsu_data;
    wr = take && sel_rd != '0;
  end
  // address/data only move on a real write, so x0 transfers leave them untouched
  always_ff @(posedge clk)
    if (rst) begin
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else begin
      we <= wr;
      if (wr) begin
        wa <= sel_rd;
        wd <= sel_data;
      end
    end
  assign bus.alu_ready = alu_ready;
  assign bus.lsu_ready = lsu_ready;
  assign bus.rf_we = we;
  assign bus.rf_wa = wa;
  assign bus.rf_wd = wd;
`ifdef WB_SCOREBOARD_EN
  logic [NREG-1:0] pend, set_m, clr_m;
  always_comb begin
    set_m = (bus.iss_valid && bus.iss_rd != '0) ? NREG'(1) << bus.iss_rd : '0;
    clr_m = wr ? NREG'(1) << sel_rd : '0;
  end
  // set is applied after clear so a same-edge issue to the same rd wins
  always_ff @(posedge clk)
    if (rst) pend <= '0;
    else pend <= (pend & ~clr_m) | set_m;
  assign bus.pending = pend;
  assign bus.iss_hazard = bus.iss_valid && (pend[bus.iss_rs1] || pend[bus.iss_rs2]);
`else
  logic unused_iss;
  assign unused_iss = ^{bus.iss_valid, bus.iss_rd, bus.iss_rs1, bus.iss_rs2};
  assign bus.pending = {NREG{1'b0}};
  assign bus.iss_hazard = 1'b0;
`endif
endmodule
